// File: rtl/demux1to8_32bit_buf.sv
// 1-to-8 routing demultiplexer: one producer fans out to eight single-entry channel buffers,
// with a broadcast mode that loads every channel in one all-or-nothing transfer.
module demux1to8_32bit_buf #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [2:0]             in_sel,
  input  logic                   in_bcast,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [NCH*WIDTH-1:0]   out_data,
  output logic [NCH-1:0]         out_valid,
  input  logic [NCH-1:0]         out_ready,
  output logic [CNT_W-1:0]       xfer_cnt,
  output logic                   busy
);

  logic [NCH-1:0]       can_s;
  logic                 in_ready_s;
  logic                 acc_s;
  logic [NCH-1:0]       load_s;
  logic [NCH*WIDTH-1:0] data_d, data_q;
  logic [NCH-1:0]       valid_d, valid_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic                 busy_d, busy_q;

  // Acceptance: a channel can take a word when empty or draining this cycle.
  always_comb begin
    can_s = ~valid_q | out_ready;
    if (in_bcast) begin
      in_ready_s = &can_s;
    end else begin
      in_ready_s = can_s[in_sel];
    end
    acc_s = in_valid & in_ready_s;
  end

  // Load mask: in_valid gates everything, so X on sel/bcast while idle never reaches state.
  always_comb begin
    load_s = {NCH{1'b0}};
    if (acc_s) begin
      if (in_bcast) begin
        load_s = {NCH{1'b1}};
      end else begin
        load_s[in_sel] = 1'b1;
      end
    end else begin
      load_s = {NCH{1'b0}};
    end
  end

  // Next state of channel buffers, transfer counter and busy flag.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int k = 0; k < NCH; k++) begin
      if (load_s[k]) begin
        data_d[k*WIDTH +: WIDTH] = in_data;
        valid_d[k]               = 1'b1;
      end else if (out_ready[k]) begin
        valid_d[k] = 1'b0;
      end else begin
        valid_d[k] = valid_q[k];
      end
    end
    if (acc_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    busy_d = |valid_d;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= {(NCH*WIDTH){1'b0}};
      valid_q <= {NCH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign xfer_cnt  = cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_demux1to8_32bit_buf.sv
// Randomized and directed bench for demux1to8_32bit_buf, checked against a queue-per-channel
// reference model built from the channel handshake rules.
module tb_demux1to8_32bit_buf;

  localparam int WIDTH = 32;
  localparam int NCH   = 8;
  localparam int CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [WIDTH-1:0]     in_data;
  logic [2:0]           in_sel;
  logic                 in_bcast;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [CNT_W-1:0]     xfer_cnt;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mq [NCH][$];
  logic [CNT_W-1:0] m_cnt;

  demux1to8_32bit_buf #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic chan_ok(input int k);
    return (mq[k].size() == 0) || out_ready[k];
  endfunction

  function automatic logic model_ready();
    logic r;
    if (in_bcast) begin
      r = 1'b1;
      for (int k = 0; k < NCH; k++) r = r & chan_ok(k);
    end else begin
      r = chan_ok(int'(in_sel));
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NCH; k++) mq[k].delete();
    m_cnt = '0;
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] ev;
    for (int k = 0; k < NCH; k++) begin
      ev[k] = (mq[k].size() != 0);
      if (ev[k]) check($sformatf("out_data[%0d]", k), out_data[k*WIDTH +: WIDTH], mq[k][0]);
    end
    check("out_valid", out_valid, ev);
    check("busy", busy, |ev);
    check("xfer_cnt", xfer_cnt, m_cnt);
  endtask

  // One clock with the inputs currently driven; called at posedge+1.
  task automatic cycle();
    logic rdy;
    logic acc;
    #1;
    rdy = model_ready();
    check("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    @(posedge clk);
    for (int k = 0; k < NCH; k++)
      if (out_ready[k] && mq[k].size() != 0) void'(mq[k].pop_front());
    if (acc) begin
      if (in_bcast) begin
        for (int k = 0; k < NCH; k++) mq[k].push_back(in_data);
      end else begin
        mq[int'(in_sel)].push_back(in_data);
      end
      m_cnt = m_cnt + 16'd1;
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic b, input logic [31:0] d);
    in_valid = v; in_sel = s; in_bcast = b; in_data = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b1, 3'd0, 1'b0, 32'h1234_5678);
    #1;
    check("rst_async_valid", out_valid, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    check("rst_out_data", out_data == '0, 1'b1);
    check_outputs();
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 8'h00;
    drive(1'b1, 3'd0, 1'b0, 32'hFFFF_0000);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("por_out_valid", out_valid, 8'h00);
    check("por_cnt", xfer_cnt, 16'h0000);
    check("por_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Build out_valid=8'h24, then reset asynchronously mid-cycle.
    drive(1'b1, 3'd2, 1'b0, 32'h2222_2222); cycle();
    drive(1'b1, 3'd5, 1'b0, 32'h5555_5555); cycle();
    check("pre_rst_valid", out_valid, 8'h24);
    #2;
    do_reset();

    // Unicast and stall on a full channel.
    out_ready = 8'h00;
    drive(1'b1, 3'd5, 1'b0, 32'hDEAD_BEEF); cycle();
    check("uni_valid", out_valid, 8'h20);
    check("uni_data5", out_data[5*WIDTH +: WIDTH], 32'hDEAD_BEEF);
    drive(1'b1, 3'd5, 1'b0, 32'hCAFE_F00D); cycle();
    check("uni_stall_ready", in_ready, 1'b0);
    out_ready = 8'h20; cycle();
    check("uni_refill_data5", out_data[5*WIDTH +: WIDTH], 32'hCAFE_F00D);
    drive(1'b0, 3'd0, 1'b0, 32'h0); cycle();

    // Streaming 1..10 into channel 3 with consumer always ready.
    do_reset();
    out_ready = 8'h08;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 3'd3, 1'b0, i);
      #1;
      check("stream_ready", in_ready, 1'b1);
      cycle();
      check("stream_word", out_data[3*WIDTH +: WIDTH], i);
    end
    check("stream_cnt", xfer_cnt, 16'd10);
    drive(1'b0, 3'd0, 1'b0, 32'h0); cycle();

    // Broadcast into empty channels, then blocked by a stalled channel 2.
    do_reset();
    out_ready = 8'h00;
    drive(1'b1, 3'd6, 1'b1, 32'h0000_A5A5); cycle();
    check("bc_valid", out_valid, 8'hFF);
    check("bc_cnt", xfer_cnt, 16'd1);
    out_ready = 8'hFB; drive(1'b0, 3'd0, 1'b0, 32'h0); cycle();
    out_ready = 8'h00;
    drive(1'b1, 3'd0, 1'b1, 32'h1111_1111); cycle();
    check("bc_block_valid", out_valid, 8'h04);
    check("bc_block_cnt", xfer_cnt, 16'd1);

    // Independence: stalled channel 0 does not block unicast to channel 1.
    do_reset();
    out_ready = 8'h00;
    drive(1'b1, 3'd0, 1'b0, 32'hA0A0_A0A0); cycle();
    drive(1'b1, 3'd1, 1'b0, 32'hB1B1_B1B1); cycle();
    check("indep_valid", out_valid, 8'h03);
    drive(1'b0, 3'd0, 1'b0, 32'h0); out_ready = 8'h01; cycle();
    check("indep_drain", out_valid, 8'h02);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 3'($urandom), ($urandom % 6) == 0, $urandom);
      out_ready = 8'($urandom);
      cycle();
    end

    // Counter wrap.
    do_reset();
    out_ready = 8'hFF;
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 3'($urandom), 1'b0, $urandom);
      cycle();
    end
    check("wrap_pre", xfer_cnt, 16'hFFFF);
    drive(1'b1, 3'd4, 1'b0, 32'h0BAD_F00D); cycle();
    check("wrap_post", xfer_cnt, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
